// File: rtl/rs485_frame_tx.sv
// RS485 frame transmitter: streams FRAME_LEN words from a synchronous memory with DIR lead/tail
// sequencing. Defining RS485_FRAME_CRC_EN appends a CRC-8 (poly 0x07) word after the last data word.
module rs485_frame_tx #(
  parameter int DATA_BITS    = 8,
  parameter int FRAME_LEN    = 20,
  parameter int ADDR_W       = 5,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DIR_LEAD     = 15,
  parameter int DIR_TAIL     = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RQ,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_W-1:0]    addr,
  output logic                 tx,
  output logic                 dirTX,
  output logic                 dirRX,
  output logic                 busy,
  output logic                 done
);

  localparam int BW   = $clog2(CLKS_PER_BIT + 1);
  localparam int DMAX = 2 * ((DIR_LEAD > DIR_TAIL) ? DIR_LEAD : DIR_TAIL);
  localparam int DW   = (DMAX == 0) ? 1 : $clog2(DMAX + 1);
  localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;

  localparam logic [BW-1:0]     BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]     BIT_PEN   = BW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        DB_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]        SB_LAST   = 4'(STOP_BITS - 1);
  localparam logic [DW-1:0]     LEAD_CNT  = DW'(DIR_LEAD);
  localparam logic [DW-1:0]     TAIL_CNT  = DW'(DIR_TAIL);
  localparam logic [DW-1:0]     LEAD_LAST = DW'(2 * DIR_LEAD - 1);
  localparam logic [DW-1:0]     TAIL_LAST = DW'(2 * DIR_TAIL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [3:0] {IDLE, DIRON, LOAD, START, DATA, PAR, STOP, DIROFF, HOLD} state_t;

  state_t               state, state_nxt;
  logic                 rq_m, rq_s;
  logic [BW-1:0]        bcnt;
  logic [3:0]           nbit;
  logic [DW-1:0]        dcnt;
  logic                 last_word;
  logic [DATA_BITS-1:0] shreg, word;
  logic                 par_bit;
  logic                 bit_end, stop_last, frame_end, addr_hold, addr_step;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign bit_end   = (bcnt == BIT_LAST);
  assign stop_last = (state == STOP) && bit_end && (nbit == SB_LAST);
  assign busy      = (state != IDLE);

`ifdef RS485_FRAME_CRC_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [DATA_BITS-1:0] d);
    logic [7:0] r;
    r = c;
    for (int i = DATA_BITS - 1; i >= 0; i--)
      r = (r[7] ^ d[i]) ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  logic [7:0] crc;
  logic       crc_phase;

  always_ff @(posedge clk) begin
    if (state == IDLE) crc <= '0;
    else if (state == LOAD && !crc_phase) crc <= crc8_step(crc, rd_data);
  end

  // crc_phase marks the extra word sent after the last memory word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crc_phase <= 1'b0;
    else if (stop_last) crc_phase <= last_word && !crc_phase;
  end

  assign word      = crc_phase ? crc : rd_data;
  assign frame_end = crc_phase;
  assign addr_hold = crc_phase;
`else
  assign word      = rd_data;
  assign frame_end = last_word;
  assign addr_hold = 1'b0;
`endif

  // addr moves one cycle ahead of LOAD so the memory output has settled by then
  always_comb begin
    addr_step = 1'b0;
    if (STOP_CYC == 1) addr_step = (state != STOP) && (state_nxt == STOP);
    else if (state == STOP) begin
      if (CLKS_PER_BIT == 1) addr_step = (nbit == 4'd0);
      else addr_step = (nbit == SB_LAST) && (bcnt == BIT_PEN);
    end
  end

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    dirTX     = 1'b1;
    dirRX     = 1'b1;
    case (state)
      IDLE: begin
        dirTX = 1'b0;
        dirRX = 1'b0;
        if (rq_s) state_nxt = (DIR_LEAD == 0) ? LOAD : DIRON;
      end
      DIRON: begin
        dirTX = (dcnt >= LEAD_CNT);
        if (dcnt == LEAD_LAST) state_nxt = LOAD;
      end
      LOAD:  state_nxt = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_end && nbit == DB_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        tx = par_bit;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (stop_last) state_nxt = !frame_end ? LOAD : (DIR_TAIL == 0) ? HOLD : DIROFF;
      end
      DIROFF: begin
        dirTX = (dcnt < TAIL_CNT);
        if (dcnt == TAIL_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        dirTX = 1'b0;
        dirRX = 1'b0;
        if (!rq_s) state_nxt = IDLE;
      end
      default: begin
        dirTX     = 1'b0;
        dirRX     = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq_m      <= 1'b0;
      rq_s      <= 1'b0;
      bcnt      <= '0;
      nbit      <= '0;
      dcnt      <= '0;
      addr      <= '0;
      last_word <= 1'b0;
      done      <= 1'b0;
    end else begin
      rq_m <= RQ;
      rq_s <= rq_m;
      done <= (state_nxt == HOLD) && (state != HOLD);
      dcnt <= ((state == DIRON || state == DIROFF) && state_nxt == state) ? dcnt + 1'b1 : '0;
      if (state inside {START, DATA, PAR, STOP}) bcnt <= bit_end ? '0 : bcnt + 1'b1;
      else bcnt <= '0;
      if (bit_end && state == DATA) nbit <= (nbit == DB_LAST) ? '0 : nbit + 1'b1;
      else if (bit_end && state == STOP) nbit <= (nbit == SB_LAST) ? '0 : nbit + 1'b1;
      else if (!(state inside {DATA, STOP})) nbit <= '0;
      if (state == LOAD) last_word <= (addr == ADDR_LAST);
      if (addr_step && !addr_hold) addr <= last_word ? '0 : addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shreg   <= word;
      par_bit <= parity_of(word);
    end else if (state == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_rs485_frame_tx.sv
// Directed bench for rs485_frame_tx: four parameterisations checked cycle by cycle against a
// waveform model of the frame format, plus reset, RQ hold and mid-frame abort checks.
module tb_rs485_frame_tx;

`ifdef RS485_FRAME_CRC_EN
  localparam int CRC_W = 1;
`else
  localparam int CRC_W = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rq = '0;
  logic [3:0] tx, dtx, drx, busy, done;
  logic [4:0] addr0, addr1;
  logic [0:0] addr2, addr3;
  logic [7:0] mem0, mem3;

  int tests = 0;
  int fails = 0;

  int c_lead [4] = '{15, 15, 0, 15};
  int c_tail [4] = '{15, 15, 0, 15};
  int c_cpb  [4] = '{1, 4, 1, 1};
  int c_par  [4] = '{0, 2, 0, 0};
  int c_stop [4] = '{1, 2, 1, 1};
  int c_flen [4] = '{20, 20, 1, 2};

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    mem0 <= 8'(addr0) * 8'd10;
    mem3 <= addr3[0] ? 8'h02 : 8'h01;
  end

  rs485_frame_tx u0 (.clk(clk), .reset(reset), .RQ(rq[0]), .rd_data(mem0), .addr(addr0),
    .tx(tx[0]), .dirTX(dtx[0]), .dirRX(drx[0]), .busy(busy[0]), .done(done[0]));
  rs485_frame_tx #(.PARITY(2), .CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (.clk(clk), .reset(reset),
    .RQ(rq[1]), .rd_data(8'h07), .addr(addr1),
    .tx(tx[1]), .dirTX(dtx[1]), .dirRX(drx[1]), .busy(busy[1]), .done(done[1]));
  rs485_frame_tx #(.FRAME_LEN(1), .ADDR_W(1), .DIR_LEAD(0), .DIR_TAIL(0)) u2 (.clk(clk),
    .reset(reset), .RQ(rq[2]), .rd_data(8'hA5), .addr(addr2),
    .tx(tx[2]), .dirTX(dtx[2]), .dirRX(drx[2]), .busy(busy[2]), .done(done[2]));
  rs485_frame_tx #(.FRAME_LEN(2), .ADDR_W(1)) u3 (.clk(clk), .reset(reset), .RQ(rq[3]),
    .rd_data(mem3), .addr(addr3),
    .tx(tx[3]), .dirTX(dtx[3]), .dirRX(drx[3]), .busy(busy[3]), .done(done[3]));

  function automatic logic [7:0] data_val(int id, int w);
    case (id)
      0:       return 8'(w * 10);
      1:       return 8'h07;
      2:       return 8'hA5;
      default: return (w == 0) ? 8'h01 : 8'h02;
    endcase
  endfunction

  function automatic logic [7:0] crc_byte(logic [7:0] c, logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] word_val(int id, int w);
    logic [7:0] c;
    if (w < c_flen[id]) return data_val(id, w);
    if (id == 3) return 8'h1B;
    c = 8'h00;
    for (int i = 0; i < c_flen[id]; i++) c = crc_byte(c, data_val(id, i));
    return c;
  endfunction

  function automatic int word_len(int id);
    return 1 + (9 + ((c_par[id] != 0) ? 1 : 0) + c_stop[id]) * c_cpb[id];
  endfunction

  function automatic int frame_len(int id);
    return 2 * c_lead[id] + (c_flen[id] + CRC_W) * word_len(id) + 2 * c_tail[id];
  endfunction

  // {tx, dirTX, dirRX, done} expected k cycles after dirRX rises
  function automatic logic [3:0] model(int id, int k);
    int L, T, C, F, WL, m, o, bi;
    logic [7:0] v;
    logic t;
    L = c_lead[id]; T = c_tail[id]; C = c_cpb[id];
    F = c_flen[id] + CRC_W; WL = word_len(id);
    if (k < 2 * L) return {1'b1, (k >= L) ? 1'b1 : 1'b0, 1'b1, 1'b0};
    m = k - 2 * L;
    if (m < F * WL) begin
      v = word_val(id, m / WL);
      o = m % WL;
      t = 1'b1;
      if (o != 0) begin
        bi = (o - 1) / C;
        if (bi == 0) t = 1'b0;
        else if (bi <= 8) t = v[bi-1];
        else if (c_par[id] != 0 && bi == 9) t = (c_par[id] == 1) ? ~^v : ^v;
      end
      return {t, 1'b1, 1'b1, 1'b0};
    end
    m = m - F * WL;
    if (m < 2 * T) return {1'b1, (m < T) ? 1'b1 : 1'b0, 1'b1, 1'b0};
    return {1'b1, 1'b0, 1'b0, (m == 2 * T) ? 1'b1 : 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic watch(input int id, input int rq_low_at, input string tag);
    logic [3:0] e;
    int fl, btx, bdt, bdr, bdn;
    bit seen;
    fl = frame_len(id);
    btx = 0; bdt = 0; bdr = 0; bdn = 0; seen = 1'b0;
    rq[id] = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (drx[id] === 1'b1);
    end
    chk({tag, "/start"}, 32'(seen), 1);
    if (seen) begin
      for (int k = 0; k <= fl + 1; k++) begin
        if (k > 0) @(negedge clk);
        if (k == rq_low_at) rq[id] = 1'b0;
        e = model(id, k);
        if (tx[id]   !== e[3]) btx++;
        if (dtx[id]  !== e[2]) bdt++;
        if (drx[id]  !== e[1]) bdr++;
        if (done[id] !== e[0]) bdn++;
      end
    end
    if (rq_low_at >= 0) rq[id] = 1'b0;
    chk({tag, "/tx_bad_cycles"}, btx, 0);
    chk({tag, "/dirTX_bad_cycles"}, bdt, 0);
    chk({tag, "/dirRX_bad_cycles"}, bdr, 0);
    chk({tag, "/done_bad_cycles"}, bdn, 0);
  endtask

  initial begin
    int n_rx, n_idle;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst/tx", 32'(tx), 32'hF);
    chk("rst/dirTX", 32'(dtx), 0);
    chk("rst/dirRX", 32'(drx), 0);
    chk("rst/busy", 32'(busy), 0);
    chk("rst/done", 32'(done), 0);
    chk("rst/addr", 32'(addr0), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle/busy", 32'(busy), 0);

    watch(0, 47, "pulse");
    repeat (4) @(negedge clk);
    chk("pulse/idle", 32'(busy[0]), 0);
    chk("pulse/addr", 32'(addr0), 0);

    watch(0, -1, "held");
    n_rx = 0; n_idle = 0;
    repeat (5000) begin
      @(negedge clk);
      if (drx[0] !== 1'b0) n_rx++;
      if (busy[0] !== 1'b1) n_idle++;
    end
    chk("held/no_repeat", n_rx, 0);
    chk("held/stays_busy", n_idle, 0);
    rq[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("held/release", 32'(busy[0]), 0);
    watch(0, 47, "second");
    repeat (4) @(negedge clk);

    watch(1, 40, "parity");
    repeat (4) @(negedge clk);
    chk("parity/idle", 32'(busy[1]), 0);

    rq[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (drx[0] === 1'b1);
    end
    chk("abort/start", 32'(seen), 1);
    repeat (90) @(negedge clk);
    chk("abort/word5_bit3", 32'(tx[0]), 0);
    chk("abort/busy_before", 32'(busy[0]), 1);
    reset = 1'b0;
    #1;
    chk("abort/tx", 32'(tx[0]), 1);
    chk("abort/dirTX", 32'(dtx[0]), 0);
    chk("abort/dirRX", 32'(drx[0]), 0);
    chk("abort/busy", 32'(busy[0]), 0);
    chk("abort/addr", 32'(addr0), 0);
    rq[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    watch(0, 47, "restart");
    repeat (4) @(negedge clk);

    watch(2, 5, "len1");
    repeat (4) @(negedge clk);
    chk("len1/idle", 32'(busy[2]), 0);

    watch(3, 20, "two_words");
    repeat (4) @(negedge clk);
    chk("two_words/addr", 32'(addr3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs485_frame_tx.md
Name: rs485_frame_tx

Overview:
- Parametrised RS485 frame transmitter that serialises a FRAME_LEN-word block from an external synchronous ROM/RAM.
- Configurable data width, bit period, parity, stop bits and DIR lead/tail timing.
- Sits between the frame memory (addr/rd_data) and the RS485 transceiver (tx, dirTX, dirRX).
- Triggered by a request from another clock domain.

Parameters:
- DATA_BITS, 8: data bits per word, 5..9, sent LSB first.
- FRAME_LEN, 20: words per frame, ≥1.
- ADDR_W, 5: address width; FRAME_LEN ≤ 2^ADDR_W.
- CLKS_PER_BIT, 1: clk cycles per serial bit, ≥1.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- DIR_LEAD, 15: cycles from dirRX rise to dirTX rise, and from dirTX rise to start of first word.
- DIR_TAIL, 15: cycles from end of last stop bit to dirTX fall, and from dirTX fall to dirRX fall.

Ports:
- clk  in  1  bit/system clock.
- reset  in  1  asynchronous, active-low reset.
- RQ  in  1  transfer request, asynchronous to clk.
- rd_data  in  DATA_BITS  memory read data, valid 1 clk after addr changes.
- addr  out  ADDR_W  memory word address.
- tx  out  1  serial line, idle high.
- dirTX  out  1  RS485 driver enable.
- dirRX  out  1  RS485 receiver direction control.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-clk pulse when a frame completes.

Behaviour:
- Reset (async, reset=0) forces tx=1, dirTX=0, dirRX=0, addr=0, busy=0, done=0, state=IDLE, all counters=0.
- Reset mid-frame aborts immediately; the next frame restarts at addr 0.
- RQ passes through a 2-FF synchroniser (rq_s); all decisions use rq_s.
- IDLE: when rq_s=1, go to DIRON (latency RQ→DIRON is 2–3 clk).
- DIRON:
  - dirRX=1 in the first DIRON cycle.
  - dirTX=1 after DIR_LEAD cycles.
  - After 2*DIR_LEAD cycles, go to LOAD.
- LOAD:
  - 1 clk; tx=1.
  - Registers rd_data (addr has been stable ≥1 clk) into the shift register and computes parity.
  - Go to START.
- START: tx=0 for CLKS_PER_BIT clk.
- DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT clk.
- PAR:
  - Present only when PARITY≠0.
  - Odd parity: tx = ~^data.
  - Even parity: tx = ^data.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT clk.
  - On the last stop cycle, addr increments.
  - If the word just sent had addr = FRAME_LEN-1: addr wraps to 0 and the state goes to DIROFF.
  - Otherwise the state goes to LOAD.
  - The LOAD cycle therefore gives exactly 1 idle clk between words.
- DIROFF:
  - tx=1.
  - dirTX=0 after DIR_TAIL cycles.
  - dirRX=0 after 2*DIR_TAIL cycles.
  - Then go to HOLD with done=1 for that one cycle.
- HOLD: wait for rq_s=0, then go to IDLE. Frames therefore never repeat without an RQ low→high edge.
- RQ during a frame:
  - Deassertion is ignored; the frame always completes.
  - Reassertion during HOLD has no effect until rq_s has been seen low.
- Counters:
  - Bit-period counter width is clog2(CLKS_PER_BIT+1).
  - DIR delay counter width covers 2*max(DIR_LEAD, DIR_TAIL).
  - No counter may overflow for legal parameters.
- Edge case: FRAME_LEN=1 sends one word, then goes to DIROFF.
- Frame length in clk from first dirRX rise to dirRX fall = 2*DIR_LEAD + FRAME_LEN*(1 + (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT) + 2*DIR_TAIL, where P = (PARITY≠0).

Optional Feature:
- Macro: RS485_FRAME_CRC_EN.
- When defined:
  - After word FRAME_LEN-1, one extra word is sent with the same framing: CRC-8, poly 0x07, init 0x00, MSB-first over the data bits as sent (DATA_BITS must be 8).
  - The CRC resets on entry to DIRON.
  - addr is not advanced for the CRC word and holds 0.
  - DIROFF follows the CRC word's stop bits.
- When undefined: no CRC logic; the frame ends after word FRAME_LEN-1.

Test Plan:
- Defaults, memory returns addr*10, pulse RQ high 50 clk:
  - dirRX rises, dirTX rises 15 clk later, start bit 15 clk after that.
  - Words 0x00, 0x0A, … 0xBE sent LSB first, 10 clk per word plus 1 idle.
  - dirTX falls 15 clk after the last stop bit, dirRX falls 15 later.
  - done pulses once.
- RQ held high 5000 clk: exactly one frame, then HOLD until RQ low. RQ low→high again: second identical frame.
- PARITY=2, CLKS_PER_BIT=4, STOP_BITS=2, rd_data=0x07 constant:
  - Each bit held 4 clk; parity bit=1.
  - Stop high for 8 clk.
  - Word length 48 clk plus 1 idle.
- Reset asserted during the DATA bit 3 of word 5: tx=1, dirTX=dirRX=0 immediately. After release and RQ: frame restarts at addr 0.
- FRAME_LEN=1, DIR_LEAD=0, DIR_TAIL=0: single word, no lead/tail gaps, done pulses; no counter underflow.
- RS485_FRAME_CRC_EN, data bytes 0x01,0x02 (FRAME_LEN=2): third word = 0x1B (CRC-8/0x07 of 0x01 0x02), then DIROFF.
